// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared constants and types for the RAM port-A arbiter.
//   M_CPU / M_DMA   : master indices (m0 = CPU data port, m1 = loader/DMA)
//   ADDR_W_DEF      : default word-address width (RAM address_a)
//   DATA_W_DEF      : default data width
//   RAM_BE_W        : byte-enable width for the default data width
//   master_sel_e    : selector for which master drives the RAM port
package ram_port_arbiter_pkg;

  localparam int unsigned M_CPU      = 0;
  localparam int unsigned M_DMA      = 1;
  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RAM_BE_W   = DATA_W_DEF / 8;

  typedef enum logic [0:0] {
    SEL_CPU = 1'b0,
    SEL_DMA = 1'b1
  } master_sel_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one master's request/response bundle towards the arbiter.
//   req/we/addr/wdata/byteena : request, held by the master until gnt
//   gnt                       : request accepted this cycle (combinational)
//   rvalid/rdata              : read data, one cycle after a granted read
// Modports: master (requester side), slave (arbiter side).
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   byteena;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, byteena,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, byteena,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_arb_starve_ctr.sv
// ram_arb_starve_ctr: saturating count of consecutive cycles a requester was
// denied; raises force_win once the count reaches LIMIT.
//   clock, reset_n : clock, asynchronous active-low reset
//   req, gnt       : the low-priority requester's request and grant
//   force_win      : count has saturated, requester must win this cycle
module ram_arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req,
  input  logic gnt,
  output logic force_win
);

  localparam int unsigned       CNT_W   = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_win = (cnt == CNT_MAX);

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port A between m0 (CPU data, priority) and
// m1 (loader/DMA). One access per cycle, same-cycle grant, read latency 1.
// m1 is forced to win after STARVE_LIMIT consecutive denied cycles.
//   clock, reset_n   : clock (shared with RAM clock_a), async active-low reset
//   m0, m1           : ram_port_arbiter_if.slave master bundles
//   ram_wren/address/data/byteena : to RAM port A
//   ram_q            : RAM port A read data (registered in the RAM)
// Optional macro RAM_ARB_STATS_EN adds stat_m0_cnt, stat_m1_cnt and
// stat_conflict_cnt (32-bit, wrapping, cleared by reset).
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ram_port_arbiter_if.slave    m0,
  ram_port_arbiter_if.slave    m1,
  output logic                 ram_wren,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [DATA_W-1:0]    ram_data,
  output logic [DATA_W/8-1:0]  ram_byteena,
  input  logic [DATA_W-1:0]    ram_q
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [31:0]          stat_m0_cnt,
  output logic [31:0]          stat_m1_cnt,
  output logic [31:0]          stat_conflict_cnt
`endif
);

  logic        force_dma;
  logic [1:0]  gnt;
  master_sel_e sel;
  logic        rd_pend_0;
  logic        rd_pend_1;

  ram_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (m1.req),
    .gnt       (gnt[M_DMA]),
    .force_win (force_dma)
  );

  // m1 wins when alone, or when it has been starved long enough.
  always_comb begin
    gnt        = '0;
    gnt[M_DMA] = m1.req & (~m0.req | force_dma);
    gnt[M_CPU] = m0.req & ~gnt[M_DMA];
    sel        = gnt[M_DMA] ? SEL_DMA : SEL_CPU;
  end

  assign m0.gnt = gnt[M_CPU];
  assign m1.gnt = gnt[M_DMA];

  // With no grant the RAM fields follow m0; wren stays low so they are inert.
  always_comb begin
    ram_wren    = (gnt[M_CPU] & m0.we) | (gnt[M_DMA] & m1.we);
    ram_address = m0.addr;
    ram_data    = m0.wdata;
    ram_byteena = m0.byteena;
    if (sel == SEL_DMA) begin
      ram_address = m1.addr;
      ram_data    = m1.wdata;
      ram_byteena = m1.byteena;
    end
  end

  // Read routing is captured at the grant edge; ram_q arrives one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_0 <= 1'b0;
      rd_pend_1 <= 1'b0;
    end else begin
      rd_pend_0 <= gnt[M_CPU] & ~m0.we;
      rd_pend_1 <= gnt[M_DMA] & ~m1.we;
    end
  end

  assign m0.rvalid = rd_pend_0;
  assign m1.rvalid = rd_pend_1;
  assign m0.rdata  = ram_q;
  assign m1.rdata  = ram_q;

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_m0_cnt       <= '0;
      stat_m1_cnt       <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (gnt[M_CPU])        stat_m0_cnt       <= stat_m0_cnt + 32'd1;
      if (gnt[M_DMA])        stat_m1_cnt       <= stat_m1_cnt + 32'd1;
      if (m0.req && m1.req)  stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
